// File: rtl/hcu_pkg.sv
// Shared types and constants for the histogram compute unit.
// Holds the update-engine state encoding and the saturating increment helper.
package hcu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD,
        S_WR,
        S_DONE
    } hcu_state_t;

    localparam int HIST_ADDR_W = 14;
    localparam int HIST_DATA_W = 8;
    localparam int HIST_DEPTH  = 16384;

    // Width-agnostic: callers pass their own maximum count.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hcu_hist_update.sv
// HCU update engine: clears every histogram bin, then performs a saturating
// read-modify-write increment per sample and pulses done after the last one.
module hcu_hist_update
    import hcu_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DATA_W = HIST_DATA_W,
    parameter int DEPTH  = HIST_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_bin,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic [ADDR_W-1:0] hist_addr_predict_HCU,
    output logic              hist_ren_predict_HCU,
    output logic              hist_wen_predict_HCU,
    output logic [DATA_W-1:0] hist_wdata_predict_HCU,
    input  logic [DATA_W-1:0] hist_rdata_predict_HCU
);

    localparam logic [DATA_W-1:0] CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    hcu_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] bin_q;
    logic              last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            clr_cnt  <= '0;
            bin_q    <= '0;
            last_q   <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        clr_cnt  <= '0;
                        sat_flag <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST)
                        state <= S_RD;
                end
                S_RD: begin
                    if (in_valid) begin
                        bin_q  <= in_bin;
                        last_q <= in_last;
                        state  <= S_WR;
                    end
                end
                S_WR: begin
                    if (hist_rdata_predict_HCU == CNT_MAX)
                        sat_flag <= 1'b1;
                    state <= last_q ? S_DONE : S_RD;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and address are decoded from state; inactive fields stay zero.
    always_comb begin
        in_ready               = 1'b0;
        busy                   = (state != S_IDLE);
        done                   = 1'b0;
        hist_addr_predict_HCU  = '0;
        hist_ren_predict_HCU   = 1'b0;
        hist_wen_predict_HCU   = 1'b0;
        hist_wdata_predict_HCU = '0;
        unique case (state)
            S_IDLE: ;
            S_CLEAR: begin
                hist_wen_predict_HCU  = 1'b1;
                hist_addr_predict_HCU = clr_cnt;
            end
            S_RD: begin
                in_ready             = 1'b1;
                hist_ren_predict_HCU = in_valid;
                if (in_valid)
                    hist_addr_predict_HCU = in_bin;
            end
            S_WR: begin
                hist_wen_predict_HCU   = 1'b1;
                hist_addr_predict_HCU  = bin_q;
                hist_wdata_predict_HCU = DATA_W'(sat_inc(
                    32'(hist_rdata_predict_HCU), 32'(CNT_MAX)));
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hcu_hist_update.sv
// Directed bench for hcu_hist_update with a 1-cycle synchronous-read
// histogram memory model and hand-computed expected values.
module tb_hcu_hist_update;
    import hcu_pkg::*;

    localparam int AW = HIST_ADDR_W;
    localparam int DW = HIST_DATA_W;
    localparam int DP = HIST_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_bin = '0;
    logic          in_last = 1'b0;
    logic          in_ready, busy, done, sat_flag;
    logic [AW-1:0] addr;
    logic          ren, wen;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;

    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hcu_hist_update dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .in_valid               (in_valid),
        .in_bin                 (in_bin),
        .in_last                (in_last),
        .in_ready               (in_ready),
        .busy                   (busy),
        .done                   (done),
        .sat_flag               (sat_flag),
        .hist_addr_predict_HCU  (addr),
        .hist_ren_predict_HCU   (ren),
        .hist_wen_predict_HCU   (wen),
        .hist_wdata_predict_HCU (wdata),
        .hist_rdata_predict_HCU (rdata)
    );

    // hist_mem_model: single port, synchronous read with 1-cycle latency.
    logic [DW-1:0] hist_mem_model [DP];

    always @(posedge clk) begin
        if (poke_en)
            hist_mem_model[poke_addr] <= poke_data;
        else if (wen)
            hist_mem_model[addr] <= wdata;
        if (ren)
            rdata <= hist_mem_model[addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < DP + 10) begin
            step();
            k++;
        end
        chk("wait_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_ren"}, {31'd0, ren}, 0);
        chk({tag, "_wen"}, {31'd0, wen}, 0);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_wdata"}, 32'(wdata), 0);
        chk({tag, "_sat"}, {31'd0, sat_flag}, 0);
    endtask

    initial begin
        int bad;
        int dones;

        // Reset state
        #2;
        chk_all_zero("rst");
        step();
        rst = 1'b0;
        step();
        chk_all_zero("idle");

        // Clear sweep; a start at clear addr 50 must be ignored
        pulse_start();
        bad = 0;
        for (int i = 0; i < DP; i++) begin
            if (i == 50) start = 1'b1;
            if (i == 51) start = 1'b0;
            if (wen !== 1'b1 || ren !== 1'b0 || wdata !== '0 ||
                in_ready !== 1'b0 || addr !== AW'(i))
                bad++;
            step();
        end
        chk("clr_seq", 32'(bad), 0);
        chk("clr_end_ready", {31'd0, in_ready}, 1);
        chk("clr_end_wen", {31'd0, wen}, 0);

        // Single sample: bin 5 holds 3
        poke(AW'(5), DW'(3));
        in_valid = 1'b1;
        in_bin   = AW'(5);
        in_last  = 1'b1;
        #1;
        chk("s1_ren", {31'd0, ren}, 1);
        chk("s1_raddr", 32'(addr), 5);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("s1_wen", {31'd0, wen}, 1);
        chk("s1_waddr", 32'(addr), 5);
        chk("s1_wdata", 32'(wdata), 4);
        chk("s1_wr_ready", {31'd0, in_ready}, 0);
        step();
        chk("s1_done", {31'd0, done}, 1);
        chk("s1_busy", {31'd0, busy}, 1);
        chk("s1_mem", 32'(hist_mem_model[5]), 4);
        step();
        chk("s1_done_low", {31'd0, done}, 0);
        chk("s1_idle", {31'd0, busy}, 0);
        chk("s1_sat", {31'd0, sat_flag}, 0);

        // Back-to-back same bin, valid held high
        pulse_start();
        wait_ready();
        in_valid = 1'b1;
        in_bin   = AW'(7);
        in_last  = 1'b0;
        dones    = 0;
        bad      = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) in_last = 1'b1;
            if (k == 5) in_valid = 1'b0;
            #1;
            if (in_ready !== ((k % 2) == 0)) bad++;
            if (done) dones++;
            step();
        end
        in_last = 1'b0;
        chk("b2b_ready_toggle", 32'(bad), 0);
        if (done) dones++;
        chk("b2b_done_now", {31'd0, done}, 1);
        step();
        if (done) dones++;
        chk("b2b_done_once", 32'(dones), 1);
        chk("b2b_mem7", 32'(hist_mem_model[7]), 3);
        chk("b2b_sat", {31'd0, sat_flag}, 0);

        // Saturation at bin 9
        pulse_start();
        wait_ready();
        poke(AW'(9), DW'(255));
        in_valid = 1'b1;
        in_bin   = AW'(9);
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("sat_wdata", 32'(wdata), 255);
        chk("sat_waddr", 32'(addr), 9);
        chk("sat_flag_pre", {31'd0, sat_flag}, 0);
        step();
        chk("sat_flag_set", {31'd0, sat_flag}, 1);
        chk("sat_done", {31'd0, done}, 1);
        step();
        chk("sat_flag_held", {31'd0, sat_flag}, 1);
        chk("sat_mem9", 32'(hist_mem_model[9]), 255);

        // Next start clears sat_flag; then reset at clear addr 100
        pulse_start();
        chk("sat_cleared", {31'd0, sat_flag}, 0);
        chk("clr2_addr0", 32'(addr), 0);
        repeat (100) step();
        chk("clr2_addr100", 32'(addr), 100);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        step();
        rst = 1'b0;
        pulse_start();
        chk("restart_wen", {31'd0, wen}, 1);
        chk("restart_addr0", 32'(addr), 0);
        step();
        chk("restart_addr1", 32'(addr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
